// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg
// Shared definitions for the UART transmit path: default byte width and the
// feeder sequencer state encoding.
package uart_tx_feeder_pkg;

    // Byte width shared by the transmitter, receiver and this feeder.
    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// uart_tx_feeder_sync_fifo
// Single-clock byte FIFO in front of the transmit sequencer.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr_en, wr_data    enqueue request; taken when not full, or when full and
//                     a pop happens in the same cycle
//   pop               dequeue the head entry (ignored when empty)
//   rd_data           head entry, combinational
//   full, empty       occupancy flags
//   count             entries held, 0..DEPTH
//   overflow          (UART_TX_FEEDER_OVF_EN only) sticky dropped-write flag
//
// Config macro: UART_TX_FEEDER_OVF_EN adds the overflow flag.
module uart_tx_feeder_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
`ifdef UART_TX_FEEDER_OVF_EN
    ,
    output logic              overflow
`endif
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    // Pointers carry one extra bit so that wr - rd yields 0..DEPTH directly.
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic              rd_acc, wr_acc;

    assign count   = wr_cnt_q - rd_cnt_q;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_cnt_q[ADDR_W-1:0]];

    // A pop frees a slot in the same cycle, so a write at full still lands.
    assign rd_acc   = pop && !empty;
    assign wr_acc   = wr_en && (!full || rd_acc);
    assign wr_cnt_d = wr_acc ? wr_cnt_q + 1'b1 : wr_cnt_q;
    assign rd_cnt_d = rd_acc ? rd_cnt_q + 1'b1 : rd_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_cnt_q[ADDR_W-1:0]] <= wr_data;
    end

`ifdef UART_TX_FEEDER_OVF_EN
    logic ovf_q, ovf_d;

    assign ovf_d    = ovf_q | (wr_en && !wr_acc);
    assign overflow = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
`endif

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Buffers host bytes and launches them one at a time into the UART
// transmitter, waiting for the transmitter's completion edge between bytes.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr_en, wr_data    host byte write
//   full, empty,count FIFO status
//   busy              sequencer is launching or waiting for completion
//   tx_start          launch strobe, high START_LEN cycles per byte
//   tx_data           byte being sent; held until the next launch
//   tx_done           transmitter completion; only its rising edge matters
//   overflow          (UART_TX_FEEDER_OVF_EN only) sticky dropped-write flag
//
// Config macro: UART_TX_FEEDER_OVF_EN adds the overflow port.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int START_LEN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done
`ifdef UART_TX_FEEDER_OVF_EN
    ,
    output logic              overflow
`endif
);

    localparam int            CNT_W    = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_LEN - 1);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_done_q;
    logic              done_rise;
    logic              pop;
    logic [DATA_W-1:0] head;

    uart_tx_feeder_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
`ifdef UART_TX_FEEDER_OVF_EN
        ,
        .overflow(overflow)
`endif
    );

    // Edge register tracks tx_done in every state, so a level already high
    // during LAUNCH does not count as completion in WAIT_DONE.
    assign done_rise = tx_done & ~tx_done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        tx_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    tx_data_d = head;
                    cnt_d     = '0;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tx_start = 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_WAIT_DONE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            ST_WAIT_DONE: begin
                if (done_rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_done_q <= tx_done;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign tx_data = tx_data_q;

endmodule
